// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment lookup for the 7-segment scan driver.
package seg7_pkg;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;
  localparam logic [1:0] ADDR_RAW   = 2'd2;

  localparam int CTRL_W      = 13;
  localparam int RAW_W       = 12;
  localparam int CTRL_MODE   = 0;
  localparam int CTRL_EN_LSB = 4;
  localparam int CTRL_DP_LSB = 8;
  localparam int CTRL_LZ     = 12;

  localparam logic [CTRL_W-1:0] CTRL_RST = 13'h00F0;
  localparam logic [RAW_W-1:0]  RAW_RST  = 12'hFFF;

  // Active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hexseg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hexseg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// CPU-mapped 4-digit common-anode display driver: hex scan with tear-free
// frame commit, leading-zero blanking and a raw pass-through mode.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [3:0]  AN,
  output logic [7:0]  BCD,
  output logic        frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);

  logic [15:0]       value_shadow;
  logic [15:0]       value_active;
  logic [CTRL_W-1:0] ctrl;
  logic [RAW_W-1:0]  raw;
  logic [PW-1:0]     presc;
  logic [1:0]        idx;

  logic       raw_mode;
  logic       mode_flip;
  logic       frame_end;
  logic [3:0] nibble;
  logic [6:0] seg;
  logic [3:0] en;
  logic [3:0] dp;
  logic [3:0] lz_zero;
  logic       digit_on;
  logic [3:0] an_nxt;
  logic [7:0] bcd_nxt;
  logic       unused_hi;

  assign unused_hi = ^wr_data[31:16];

  assign raw_mode   = ctrl[CTRL_MODE];
  assign mode_flip  = wr_en && (wr_addr == ADDR_CTRL) && (wr_data[CTRL_MODE] != ctrl[CTRL_MODE]);
  assign frame_end  = !raw_mode && (presc == LAST) && (idx == 2'd3);
  assign frame_tick = frame_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_shadow <= 16'h0000;
      ctrl         <= CTRL_RST;
      raw          <= RAW_RST;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_VALUE: value_shadow <= wr_data[15:0];
        ADDR_CTRL:  ctrl         <= wr_data[CTRL_W-1:0];
        ADDR_RAW:   raw          <= wr_data[RAW_W-1:0];
        default:    ;
      endcase
    end
  end

  // The active copy only changes at the frame boundary, so a frame never mixes two values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      idx          <= 2'd0;
      value_active <= 16'h0000;
    end else begin
      if (frame_end)
        value_active <= value_shadow;
      if (mode_flip || raw_mode) begin
        presc <= '0;
        idx   <= 2'd0;
      end else if (presc == LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign nibble = value_active[{idx, 2'b00} +: 4];
  assign en     = ctrl[CTRL_EN_LSB +: 4];
  assign dp     = ctrl[CTRL_DP_LSB +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

  // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
  always_comb begin
    lz_zero    = 4'b0000;
    lz_zero[3] = (value_active[15:12] == 4'h0);
    lz_zero[2] = lz_zero[3] && (value_active[11:8] == 4'h0);
    lz_zero[1] = lz_zero[2] && (value_active[7:4] == 4'h0);
  end

  assign digit_on = en[idx] && !(ctrl[CTRL_LZ] && lz_zero[idx]);

  always_comb begin
    an_nxt  = 4'hF;
    bcd_nxt = 8'hFF;
    if (raw_mode) begin
      an_nxt  = raw[11:8];
      bcd_nxt = raw[7:0];
    end else if (presc >= BLANK) begin
      an_nxt  = digit_on ? ~(4'b0001 << idx) : 4'hF;
      bcd_nxt = ~{dp[idx], seg};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AN  <= 4'hF;
      BCD <= 8'hFF;
    end else begin
      AN  <= an_nxt;
      BCD <= bcd_nxt;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (rd_addr)
      ADDR_VALUE: rd_data = {16'h0000, value_shadow};
      ADDR_CTRL:  rd_data = {{(32-CTRL_W){1'b0}}, ctrl};
      ADDR_RAW:   rd_data = {{(32-RAW_W){1'b0}}, raw};
      default:    rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV = 8, BLANK_CYCLES = 2.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'h0;
  logic [1:0]  rd_addr = 2'd0;
  logic [31:0] rd_data;
  logic [3:0]  AN;
  logic [7:0]  BCD;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .AN         (AN),
    .BCD        (BCD),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_now(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] e);
    rd_addr = a;
    #1;
    chk(tag, rd_data, e);
  endtask

  // One 32-cycle frame from slot 0 / prescaler 0. an_e/bcd_e hold slot 0 in the LSBs.
  // Up to two writes are issued at frame steps ws0/ws1 (-1 = none).
  task automatic frame(input string tag, input logic [15:0] an_e, input logic [31:0] bcd_e,
                       input int ws0, input logic [1:0] wa0, input logic [31:0] wd0,
                       input int ws1, input logic [1:0] wa1, input logic [31:0] wd1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        int j;
        j = s * 8 + c;
        if (j == ws0) begin
          wr_en = 1'b1; wr_addr = wa0; wr_data = wd0;
        end else if (j == ws1) begin
          wr_en = 1'b1; wr_addr = wa1; wr_data = wd1;
        end
        tick();
        wr_en = 1'b0;
        chk({tag, " AN"},  {28'h0, AN},  (c < 2) ? 32'hF  : {28'h0, an_e[4*s +: 4]});
        chk({tag, " BCD"}, {24'h0, BCD}, (c < 2) ? 32'hFF : {24'h0, bcd_e[8*s +: 8]});
        chk({tag, " tick"}, {31'h0, frame_tick}, (s == 3 && c == 6) ? 32'h1 : 32'h0);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst AN", {28'h0, AN}, 32'hF);
    chk("rst BCD", {24'h0, BCD}, 32'hFF);
    chk("rst tick", {31'h0, frame_tick}, 32'h0);
    rd_chk("rst VALUE", 2'd0, 32'h0);
    rd_chk("rst CTRL", 2'd1, 32'h00F0);
    rd_chk("rst RAW", 2'd2, 32'hFFF);
    reset = 1'b0;

    // 1: free-run with VALUE = 0
    frame("t1", 16'h7BDE, 32'hC0C0C0C0, -1, 2'd0, 32'h0, -1, 2'd0, 32'h0);

    // 2: mid-frame VALUE write is not shown until the next frame
    frame("t2a", 16'h7BDE, 32'hC0C0C0C0, 12, 2'd0, 32'h12AF, -1, 2'd0, 32'h0);
    rd_chk("t2 shadow", 2'd0, 32'h12AF);
    frame("t2b", 16'h7BDE, 32'hF9A4888E, 2, 2'd0, 32'h0005, 3, 2'd1, 32'h10F0);
    rd_chk("t3 ctrl", 2'd1, 32'h10F0);

    // 3: leading-zero blank with VALUE = 0005
    frame("t3", 16'hFFFE, 32'hC0C0C092, -1, 2'd0, 32'h0, -1, 2'd0, 32'h0);

    // 4: dp on digit 1, then digit 2 disabled
    frame("t4", 16'h7BDE, 32'hC0C04092, 0, 2'd1, 32'h02F0, -1, 2'd0, 32'h0);
    frame("t4b", 16'h7FDE, 32'hC0C0C092, 0, 2'd1, 32'h00B0, -1, 2'd0, 32'h0);

    // 5: raw mode
    wr_now(2'd1, 32'h00F1);
    chk("t5 ctrl-wr AN", {28'h0, AN}, 32'hF);
    wr_now(2'd2, 32'h07A4);
    chk("t5 raw-wr AN", {28'h0, AN}, 32'hF);
    chk("t5 raw-wr BCD", {24'h0, BCD}, 32'hFF);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5 raw AN", {28'h0, AN}, 32'h7);
      chk("t5 raw BCD", {24'h0, BCD}, 32'hA4);
      chk("t5 raw tick", {31'h0, frame_tick}, 32'h0);
    end
    rd_chk("t5 RAW rd", 2'd2, 32'h7A4);
    rd_chk("t5 CTRL rd", 2'd1, 32'h00F1);
    wr_now(2'd1, 32'h00F0);
    chk("t5 back AN", {28'h0, AN}, 32'h7);
    chk("t5 back BCD", {24'h0, BCD}, 32'hA4);
    frame("t5b", 16'h7BDE, 32'hC0C0C092, -1, 2'd0, 32'h0, -1, 2'd0, 32'h0);

    // 6: async reset in the digit-2 active window
    repeat (19) tick();
    chk("t6 pre AN", {28'h0, AN}, 32'hB);
    chk("t6 pre BCD", {24'h0, BCD}, 32'hC0);
    reset = 1'b1;
    #1;
    chk("t6 async AN", {28'h0, AN}, 32'hF);
    chk("t6 async BCD", {24'h0, BCD}, 32'hFF);
    chk("t6 async tick", {31'h0, frame_tick}, 32'h0);
    rd_chk("t6 VALUE", 2'd0, 32'h0);
    rd_chk("t6 CTRL", 2'd1, 32'h00F0);
    rd_chk("t6 RAW", 2'd2, 32'hFFF);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    frame("t6b", 16'h7BDE, 32'hC0C0C0C0, -1, 2'd0, 32'h0, -1, 2'd0, 32'h0);

    // Reserved address: write ignored, reads 0
    wr_now(2'd3, 32'hFFFF_FFFF);
    rd_chk("rsv rd", 2'd3, 32'h0);
    rd_chk("rsv VALUE", 2'd0, 32'h0);
    rd_chk("rsv CTRL", 2'd1, 32'h00F0);
    rd_chk("rsv RAW", 2'd2, 32'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Memory-mapped display peripheral downstream of the PipelineCPU core on the xc7a35t board. It takes CPU bus writes and drives the board's 4-digit common-anode 7-segment display on AN/BCD. Two modes: hardware hex scan, where the CPU writes a 16-bit value, and raw mode, where the CPU writes AN/BCD directly.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off (anti-ghosting). Must be < SCAN_DIV; 0 is allowed.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- wr_en  in  1  single-cycle write strobe from the CPU data bus
- wr_addr  in  2  0 = VALUE, 1 = CTRL, 2 = RAW, 3 = reserved (write ignored)
- wr_data  in  32  write data
- rd_addr  in  2  read select
- rd_data  out  32  combinational read of the selected register; zero-extended; addr 3 reads 0
- AN  out  4  anode enables, active-low; AN[0] = rightmost digit
- BCD  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
- frame_tick  out  1  one-cycle pulse at the end of the digit-3 slot (hex mode only)

Behaviour:
- Registers:
  - VALUE[15:0]: shadow plus active copy.
  - CTRL: bit0 mode (0 = hex, 1 = raw), bits7:4 digit enable, bits11:8 per-digit dp, bit12 leading-zero blank.
  - RAW: bits11:8 AN, bits7:0 BCD, both active-low as written.
- Reset values:
  - VALUE shadow and active = 0; CTRL = 0x00F0; RAW = 0xFFF.
  - Prescaler = 0; digit index = 0.
  - AN = 4'hF, BCD = 8'hFF, frame_tick = 0.
- Writes take effect in the cycle after wr_en. rd_data for VALUE returns the shadow copy.
- Hex-mode scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and the digit index increments mod 4 (0→1→2→3→0).
- Within a slot:
  - While prescaler < BLANK_CYCLES: AN = 4'hF and BCD = 8'hFF.
  - Otherwise: AN[idx] = 0 if the digit is enabled and not LZ-blanked, else all-high. BCD = ~{dp[idx], hexseg(nibble idx of active VALUE)}.
- Tear-free update: the active VALUE loads from the shadow only on the cycle the prescaler wraps with idx = 3. The same cycle pulses frame_tick.
- Shadow write on the commit cycle: the commit uses the old shadow; the new write lands in the shadow and commits at the next frame.
- LZ blank (CTRL bit12 = 1):
  - Digit k (k = 3..1) is blanked when nibbles k..3 of the active VALUE are all zero.
  - Digit 0 is never blanked. VALUE = 0 shows a single "0".
- A disabled digit keeps its time slot and outputs AN all-high. Scan timing is unchanged.
- Raw mode: AN = RAW[11:8] and BCD = RAW[7:0], registered, one cycle after the RAW write. The prescaler and digit index are held at 0, and frame_tick = 0.
- Any CTRL write that changes bit0:
  - Resets the prescaler and index to 0 (the new slot starts with its blank interval).
  - The output switches source on the next cycle.
- AN/BCD are registered. They reflect the prescaler/index/register state of cycle n at cycle n+1, so they are glitch-free.
- Asynchronous reset mid-scan forces all outputs and state to reset values immediately. Scan restarts at digit 0 after deassertion.

Decomposition:
- Package seg7_pkg holds:
  - address constants (ADDR_VALUE/CTRL/RAW);
  - CTRL bit-position constants;
  - the CTRL reset value (0x00F0) and RAW reset value (0xFFF);
  - the hexseg() 16-entry active-high segment function (0 = 0x3F … F = 0x71).
- One natural sub-module: seg7_hex_decode, a combinational nibble → 7-segment decoder, instantiated once on the muxed nibble.

Test Plan:
All scenarios use SCAN_DIV = 8 and BLANK_CYCLES = 2.
1. Reset, then free-run: AN cycles through E, D, B, 7. Each slot has 2 cycles of F followed by 6 cycles active. With VALUE = 0, BCD = 0xC0 when active. frame_tick pulses every 32 cycles.
2. Write VALUE = 0x12AF mid-frame: the display keeps the old value until the next frame_tick, then shows F, A, 2, 1 on AN E, D, B, 7 (BCD 0x8E, 0x88, 0xA4, 0xF9).
3. CTRL = 0x10F0 with VALUE = 0x0005: AN stays F in the digit-3/2/1 active windows. Digit 0 shows 0x92.
4. CTRL = 0x02F0 (dp on digit 1): BCD bit7 = 0 only in the digit-1 slot.
5. CTRL = 0x00F1, then RAW = 0x7A4: the next cycle gives AN = 7, BCD = 0xA4, held indefinitely with no frame_tick. Writing CTRL back to 0x00F0 restarts the scan at digit 0 with its blank interval.
6. Assert reset during the digit-2 active window: AN = F and BCD = FF asynchronously. After release, the first active digit is AN = E.
